// File: rtl/axis_pkt_echo_pkg.sv
// ============================================================================
// Module   : axis_pkt_echo_pkg
// Brief    : Shared types and default widths for the packet echo block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_pkt_echo_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;
    localparam int DEPTH_DEF  = 512;

    typedef struct packed {
        logic                  last;
        logic [KEEP_W_DEF-1:0] keep;
        logic [DATA_W_DEF-1:0] data;
    } beat_t;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } in_state_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } out_state_t;

    // Stored record width for an arbitrary data width: {last, keep, data}.
    function automatic int beat_width(input int data_w);
        return data_w + (data_w / 8) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_echo_ram.sv
// ============================================================================
// Module   : axis_pkt_echo_ram
// Brief    : Simple dual-port beat buffer, one write port, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_echo_ram
    import axis_pkt_echo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WIDTH  = beat_width(DATA_W_DEF),
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Read data holds while rd_en is low so a stalled pipeline keeps its beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/axis_pkt_echo.sv
// ============================================================================
// Module   : axis_pkt_echo
// Brief    : Store-and-forward AXI4-Stream echo; oversize packets are dropped.
// Options  : AXIS_PKT_ECHO_STATS_EN adds rx/tx/drop 32-bit packet counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_pkt_echo
    import axis_pkt_echo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                sys_reset,
    input  logic [DATA_W-1:0]   stream_in_tdata,
    input  logic [DATA_W/8-1:0] stream_in_tkeep,
    input  logic                stream_in_tlast,
    input  logic                stream_in_tvalid,
    output logic                stream_in_tready,
    output logic [DATA_W-1:0]   stream_out_tdata,
    output logic [DATA_W/8-1:0] stream_out_tkeep,
    output logic                stream_out_tlast,
    output logic                stream_out_tvalid,
    input  logic                stream_out_tready,
    output logic                pkt_drop,
    output logic [ADDR_W:0]     fifo_level
`ifdef AXIS_PKT_ECHO_STATS_EN
    ,
    output logic [31:0]         rx_pkt_count,
    output logic [31:0]         tx_pkt_count,
    output logic [31:0]         drop_count
`endif
);

    localparam int               KEEP_W   = DATA_W / 8;
    localparam int               BEAT_W   = beat_width(DATA_W);
    localparam int               PTR_W    = ADDR_W + 1;
    localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    in_state_t         in_state_q, in_state_d;
    out_state_t        out_state_q, out_state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  commit_ptr_q, commit_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  fetch_ptr_q, fetch_ptr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              out_vld_q, out_vld_d;
    logic [BEAT_W-1:0] out_beat_q, out_beat_d;
    logic              in_tready_q, in_tready_d;
    logic              pkt_drop_q, pkt_drop_d;
    logic [PTR_W-1:0]  fifo_level_q, fifo_level_d;

    logic              full, in_hs, out_hs, commit_evt, stage_move, avail, ram_re;
    logic [BEAT_W-1:0] ram_rdata;

    assign full       = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign in_hs      = stream_in_tvalid & in_tready_q;
    assign out_hs     = out_vld_q & stream_out_tready;
    assign commit_evt = (in_state_q == ACCEPT) & in_hs & stream_in_tlast;
    assign stage_move = rd_vld_q & (~out_vld_q | stream_out_tready);
    assign avail      = commit_ptr_q != fetch_ptr_q;

    always_comb begin
        in_state_d   = in_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        pkt_drop_d   = 1'b0;
        if (in_state_q == ACCEPT) begin
            if (in_hs) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (stream_in_tlast) begin
                    commit_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end else if (full && stream_in_tvalid && (commit_ptr_q == rd_ptr_q)) begin
                // Whole buffer holds one unfinished packet: it can never fit.
                in_state_d = DROP;
                wr_ptr_d   = commit_ptr_q;
            end
        end else if (in_hs && stream_in_tlast) begin
            pkt_drop_d = 1'b1;
            in_state_d = ACCEPT;
        end
    end

    // rd_ptr frees a slot only when its beat leaves the output register;
    // fetch_ptr runs ahead through the two-stage read pipeline.
    always_comb begin
        out_state_d = out_state_q;
        if (out_state_q == IDLE) begin
            if (avail) begin
                out_state_d = SEND;
            end
        end else if (out_hs && out_beat_q[BEAT_W-1] && !rd_vld_q && !avail) begin
            out_state_d = IDLE;
        end
        ram_re       = (out_state_d == SEND) && avail && (!rd_vld_q || stage_move);
        fetch_ptr_d  = fetch_ptr_q + PTR_W'(ram_re);
        rd_ptr_d     = rd_ptr_q + PTR_W'(out_hs);
        rd_vld_d     = ram_re ? 1'b1 : (stage_move ? 1'b0 : rd_vld_q);
        out_vld_d    = stage_move ? 1'b1 : (out_hs ? 1'b0 : out_vld_q);
        out_beat_d   = stage_move ? ram_rdata : out_beat_q;
        fifo_level_d = wr_ptr_d - rd_ptr_d;
        in_tready_d  = (in_state_d == DROP) || (fifo_level_d != FULL_LVL);
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            in_state_q   <= ACCEPT;
            out_state_q  <= IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            fetch_ptr_q  <= '0;
            rd_vld_q     <= 1'b0;
            out_vld_q    <= 1'b0;
            out_beat_q   <= '0;
            in_tready_q  <= 1'b0;
            pkt_drop_q   <= 1'b0;
            fifo_level_q <= '0;
        end else begin
            in_state_q   <= in_state_d;
            out_state_q  <= out_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            rd_vld_q     <= rd_vld_d;
            out_vld_q    <= out_vld_d;
            out_beat_q   <= out_beat_d;
            in_tready_q  <= in_tready_d;
            pkt_drop_q   <= pkt_drop_d;
            fifo_level_q <= fifo_level_d;
        end
    end

    axis_pkt_echo_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (BEAT_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   ((in_state_q == ACCEPT) & in_hs),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data ({stream_in_tlast, stream_in_tkeep, stream_in_tdata}),
        .rd_en   (ram_re),
        .rd_addr (fetch_ptr_q[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    assign stream_in_tready  = in_tready_q;
    assign stream_out_tvalid = out_vld_q;
    assign stream_out_tdata  = out_beat_q[DATA_W-1:0];
    assign stream_out_tkeep  = out_beat_q[DATA_W +: KEEP_W];
    assign stream_out_tlast  = out_beat_q[BEAT_W-1];
    assign pkt_drop          = pkt_drop_q;
    assign fifo_level        = fifo_level_q;

`ifdef AXIS_PKT_ECHO_STATS_EN
    logic [31:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        rx_cnt_d   = rx_cnt_q + 32'(commit_evt);
        tx_cnt_d   = tx_cnt_q + 32'(out_hs & out_beat_q[BEAT_W-1]);
        drop_cnt_d = drop_cnt_q + 32'(pkt_drop_d);
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            rx_cnt_q   <= '0;
            tx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rx_cnt_q   <= rx_cnt_d;
            tx_cnt_q   <= tx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign rx_pkt_count = rx_cnt_q;
    assign tx_pkt_count = tx_cnt_q;
    assign drop_count   = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_pkt_echo.sv
// ============================================================================
// Module   : tb_axis_pkt_echo
// Brief    : Scoreboard bench for axis_pkt_echo (DEPTH=8, DATA_W=64).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_pkt_echo;
    import axis_pkt_echo_pkg::*;

    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              sys_reset = 1'b1;
    logic [DATA_W-1:0] in_tdata = '0;
    logic [KEEP_W-1:0] in_tkeep = '0;
    logic              in_tlast = 1'b0;
    logic              in_tvalid = 1'b0;
    logic              stream_in_tready;
    logic [DATA_W-1:0] stream_out_tdata;
    logic [KEEP_W-1:0] stream_out_tkeep;
    logic              stream_out_tlast;
    logic              stream_out_tvalid;
    logic              out_tready = 1'b0;
    logic              pkt_drop;
    logic [ADDR_W:0]   fifo_level;
`ifdef AXIS_PKT_ECHO_STATS_EN
    logic [31:0]       rx_pkt_count, tx_pkt_count, drop_count;
`endif

    axis_pkt_echo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk               (clk),
        .sys_reset         (sys_reset),
        .stream_in_tdata   (in_tdata),
        .stream_in_tkeep   (in_tkeep),
        .stream_in_tlast   (in_tlast),
        .stream_in_tvalid  (in_tvalid),
        .stream_in_tready  (stream_in_tready),
        .stream_out_tdata  (stream_out_tdata),
        .stream_out_tkeep  (stream_out_tkeep),
        .stream_out_tlast  (stream_out_tlast),
        .stream_out_tvalid (stream_out_tvalid),
        .stream_out_tready (out_tready),
        .pkt_drop          (pkt_drop),
        .fifo_level        (fifo_level)
`ifdef AXIS_PKT_ECHO_STATS_EN
        ,
        .rx_pkt_count      (rx_pkt_count),
        .tx_pkt_count      (tx_pkt_count),
        .drop_count        (drop_count)
`endif
    );

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q[$];
    beat_t pkt_q[$];
    beat_t out_beat;
    int    cyc = 0;
    int    acc_edge = 0;
    int    out_mode = 0;
    bit    watch_early = 1'b0;
    int    early_viol = 0;
    int    bubble_cnt = 0;
    int    drop_seen = 0;
    int    tx_seen = 0;
    int    exp_tx = 0;
    int    exp_drops = 0;

    assign out_beat = {stream_out_tlast, stream_out_tkeep, stream_out_tdata};

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Downstream ready: 0 = hold off, 1 = always ready, 2 = random.
    initial forever begin
        @(posedge clk);
        #1;
        case (out_mode)
            0:       out_tready = 1'b0;
            1:       out_tready = 1'b1;
            default: out_tready = ($urandom_range(3, 0) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : monitor
        bit    stall_prev;
        bit    mid_pkt;
        beat_t stall_beat;
        beat_t exp_b;
        stall_prev = 1'b0;
        mid_pkt    = 1'b0;
        stall_beat = '0;
        forever begin
            @(negedge clk);
            if (sys_reset) begin
                stall_prev = 1'b0;
                mid_pkt    = 1'b0;
            end else begin
                if (watch_early && stream_out_tvalid) early_viol++;
                if (mid_pkt && !stream_out_tvalid) bubble_cnt++;
                if (stall_prev) begin
                    check("hold_valid", stream_out_tvalid, 1'b1);
                    check("hold_payload", out_beat, stall_beat);
                end
                if (stream_out_tvalid && out_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out actual=%0h required=none", out_beat);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("out_beat", out_beat, exp_b);
                    end
                    if (stream_out_tlast) tx_seen++;
                    mid_pkt = !stream_out_tlast;
                end
                stall_prev = stream_out_tvalid && !out_tready;
                stall_beat = out_beat;
                if (pkt_drop) drop_seen++;
            end
        end
    end

    // All driving tasks start and end just after a rising edge.
    task automatic drive_beat(input beat_t b, input int gap_max, output bit ok);
        int gap;
        int t;
        ok  = 1'b0;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_tvalid = 1'b1;
        in_tdata  = b.data;
        in_tkeep  = b.keep;
        in_tlast  = b.last;
        t = 0;
        while (!ok && t < 3000) begin
            @(negedge clk);
            if (stream_in_tready) begin
                acc_edge = cyc + 1;
                ok = 1'b1;
            end
            t++;
            @(posedge clk);
            #1;
        end
        in_tvalid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL in_handshake_timeout actual=no_ready required=ready");
        end
    endtask

    // Reference rule: packets longer than DEPTH are dropped, all others echo verbatim.
    task automatic send_pkt(input int gap_max);
        bit ok;
        if (pkt_q.size() > DEPTH) begin
            exp_drops++;
        end else begin
            foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
            exp_tx++;
        end
        foreach (pkt_q[i]) begin
            drive_beat(pkt_q[i], gap_max, ok);
            if (!ok) break;
        end
        watch_early = 1'b0;
    endtask

    task automatic make_pkt(input int len);
        beat_t b;
        pkt_q.delete();
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom};
            b.keep = KEEP_W'($urandom);
            b.last = (i == len - 1);
            pkt_q.push_back(b);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || stream_out_tvalid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int    t;
        int    d0;
        int    tx_base;
        bit    ok;
        beat_t b;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_tready", stream_in_tready, 1'b0);
        check("rst_out_tvalid", stream_out_tvalid, 1'b0);
        check("rst_out_beat", out_beat, '0);
        check("rst_pkt_drop", pkt_drop, 1'b0);
        check("rst_fifo_level", fifo_level, 0);
        @(posedge clk);
        #1;
        sys_reset = 1'b0;
        @(posedge clk);
        #1;
        check("in_tready_after_reset", stream_in_tready, 1'b1);

        // Single beat and its latency from the accepting edge.
        out_mode = 1;
        pkt_q.delete();
        b.data = 64'h0123456789ABCDEF;
        b.keep = 8'hFF;
        b.last = 1'b1;
        pkt_q.push_back(b);
        send_pkt(0);
        t = 0;
        while (!stream_out_tvalid && t < 20) begin @(negedge clk); t++; end
        check("first_latency", cyc - acc_edge, 2);
        drain();

        // Four beats: nothing may appear before the tlast handshake.
        pkt_q.delete();
        for (int i = 1; i <= 4; i++) begin
            b.data = 64'(i);
            b.keep = (i == 4) ? 8'h0F : 8'hFF;
            b.last = (i == 4);
            pkt_q.push_back(b);
        end
        watch_early = 1'b1;
        send_pkt(1);
        check("no_early_valid", early_viol, 0);
        drain();

        // Two committed packets fill the buffer; the third must stall, not drop.
        out_mode = 0;
        make_pkt(4);
        send_pkt(0);
        make_pkt(4);
        send_pkt(0);
        d0 = drop_seen;
        make_pkt(4);
        fork
            send_pkt(0);
            begin
                repeat (12) @(negedge clk);
                check("stall_in_tready", stream_in_tready, 1'b0);
                check("stall_fifo_level", fifo_level, DEPTH);
                check("stall_no_drop", drop_seen, d0);
                out_mode = 1;
            end
        join
        drain();

        // Oversize packet into an empty buffer.
        make_pkt(DEPTH + 1);
        send_pkt(0);
        check("drop_pulse_on_last", pkt_drop, 1'b1);
        @(posedge clk);
        #1;
        check("drop_pulse_width", pkt_drop, 1'b0);
        check("drop_fifo_level", fifo_level, 0);
        make_pkt(2);
        send_pkt(0);
        drain();
        check("drop_seen", drop_seen, exp_drops);

        // Random traffic on both sides.
        out_mode = 2;
        tx_base  = tx_seen;
        for (int p = 0; p < 100; p++) begin
            make_pkt(int'($urandom_range(DEPTH, 1)));
            send_pkt(2);
        end
        out_mode = 1;
        drain();
        check("random_tx_packets", tx_seen - tx_base, 100);
        check("total_tx_packets", tx_seen, exp_tx);
`ifdef AXIS_PKT_ECHO_STATS_EN
        check("stat_rx", rx_pkt_count, exp_tx);
        check("stat_tx", tx_pkt_count, exp_tx);
        check("stat_drop", drop_count, exp_drops);
`endif

        // Reset with a committed packet pending and a partial packet in flight.
        out_mode = 0;
        make_pkt(2);
        send_pkt(0);
        make_pkt(4);
        drive_beat(pkt_q[0], 0, ok);
        drive_beat(pkt_q[1], 0, ok);
        sys_reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        sys_reset = 1'b0;
        check("mid_rst_in_tready", stream_in_tready, 1'b0);
        check("mid_rst_out_tvalid", stream_out_tvalid, 1'b0);
        check("mid_rst_out_beat", out_beat, '0);
        check("mid_rst_pkt_drop", pkt_drop, 1'b0);
        check("mid_rst_fifo_level", fifo_level, 0);
        out_mode = 1;
        @(posedge clk);
        #1;
        make_pkt(3);
        send_pkt(0);
        drain();
`ifdef AXIS_PKT_ECHO_STATS_EN
        check("post_rst_stat_rx", rx_pkt_count, 1);
        check("post_rst_stat_tx", tx_pkt_count, 1);
        check("post_rst_stat_drop", drop_count, 0);
`endif

        repeat (4) @(posedge clk);
        check("no_bubbles", bubble_cnt, 0);
        check("total_drops", drop_seen, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
